// File: rtl/decode_stage.sv
// Decode stage: splits RV32I fields, reads the register file, builds immediates and
// control bits, inserts load-use bubbles and registers the result for execute.
module decode_stage #(
    parameter int          NUM_REGS = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction_dec,
    input  logic [31:0] pc_dec,
    input  logic        branch,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall_fe,
    output logic [31:0] rs1_data_ex,
    output logic [31:0] rs2_data_ex,
    output logic [31:0] imm_ex,
    output logic [4:0]  rd_ex,
    output logic [4:0]  rs1_ex,
    output logic [4:0]  rs2_ex,
    output logic [6:0]  opcode_ex,
    output logic [2:0]  funct3_ex,
    output logic [6:0]  funct7_ex,
    output logic [31:0] pc_exe,
    output logic        mem_read_ex,
    output logic        mem_write_ex,
    output logic        reg_write_ex,
    output logic        valid_ex,
    output logic        illegal_ex
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] pc;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        valid;
        logic        illegal;
    } ex_t;

    logic [31:0] regs [NUM_REGS];
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic        writes_rd;
    logic        illegal;
    logic        hazard;
    logic        bubble;
    ex_t         ex_d;
    ex_t         ex_q;

    assign opcode = instruction_dec[6:0];
    assign rd     = instruction_dec[11:7];
    assign rs1    = instruction_dec[19:15];
    assign rs2    = instruction_dec[24:20];

    // x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // A same-cycle writeback to the source register wins over the stored value.
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 :
                     (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 :
                     (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];

    always_comb begin
        imm       = '0;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        unique case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: begin
                imm       = {{20{instruction_dec[31]}}, instruction_dec[31:20]};
                writes_rd = 1'b1;
            end
            OP_STORE:
                imm = {{20{instruction_dec[31]}}, instruction_dec[31:25], instruction_dec[11:7]};
            OP_BRANCH:
                imm = {{19{instruction_dec[31]}}, instruction_dec[31], instruction_dec[7],
                       instruction_dec[30:25], instruction_dec[11:8], 1'b0};
            OP_LUI, OP_AUIPC: begin
                imm       = {instruction_dec[31:12], 12'b0};
                writes_rd = 1'b1;
            end
            OP_JAL: begin
                imm       = {{11{instruction_dec[31]}}, instruction_dec[31], instruction_dec[19:12],
                             instruction_dec[20], instruction_dec[30:21], 1'b0};
                writes_rd = 1'b1;
            end
            OP_OP:   writes_rd = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    // stall_fe asks fetch to present the same instruction again next cycle;
    // a flush overrides it because the held instruction is on the wrong path.
    assign hazard   = ex_q.mem_read & ex_q.valid & (ex_q.rd != 5'd0) &
                      ((ex_q.rd == rs1) | (ex_q.rd == rs2));
    assign stall_fe = hazard & ~branch;
    assign bubble   = branch | hazard | (instruction_dec == 32'd0);

    always_comb begin
        ex_d    = '0;
        ex_d.pc = RESET_PC;
        if (!bubble) begin
            ex_d.rs1_data  = rs1_val;
            ex_d.rs2_data  = rs2_val;
            ex_d.imm       = imm;
            ex_d.rd        = rd;
            ex_d.rs1       = rs1;
            ex_d.rs2       = rs2;
            ex_d.opcode    = opcode;
            ex_d.funct3    = instruction_dec[14:12];
            ex_d.funct7    = instruction_dec[31:25];
            ex_d.pc        = pc_dec;
            ex_d.mem_read  = (opcode == OP_LOAD);
            ex_d.mem_write = (opcode == OP_STORE);
            ex_d.reg_write = writes_rd & (rd != 5'd0);
            ex_d.valid     = 1'b1;
            ex_d.illegal   = illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            ex_q.pc <= RESET_PC;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign rs1_data_ex  = ex_q.rs1_data;
    assign rs2_data_ex  = ex_q.rs2_data;
    assign imm_ex       = ex_q.imm;
    assign rd_ex        = ex_q.rd;
    assign rs1_ex       = ex_q.rs1;
    assign rs2_ex       = ex_q.rs2;
    assign opcode_ex    = ex_q.opcode;
    assign funct3_ex    = ex_q.funct3;
    assign funct7_ex    = ex_q.funct7;
    assign pc_exe       = ex_q.pc;
    assign mem_read_ex  = ex_q.mem_read;
    assign mem_write_ex = ex_q.mem_write;
    assign reg_write_ex = ex_q.reg_write;
    assign valid_ex     = ex_q.valid;
    assign illegal_ex   = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: constant vector table, hand-written stall/flush/reset
// sequences, then random traffic against a field-arithmetic reference model.
module tb_decode_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction_dec = '0;
    logic [31:0] pc_dec = '0;
    logic        branch = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        stall_fe;
    logic [31:0] rs1_data_ex, rs2_data_ex, imm_ex, pc_exe;
    logic [4:0]  rd_ex, rs1_ex, rs2_ex;
    logic [6:0]  opcode_ex, funct7_ex;
    logic [2:0]  funct3_ex;
    logic        mem_read_ex, mem_write_ex, reg_write_ex, valid_ex, illegal_ex;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.NUM_REGS(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .instruction_dec(instruction_dec), .pc_dec(pc_dec),
        .branch(branch), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_fe(stall_fe), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
        .imm_ex(imm_ex), .rd_ex(rd_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .opcode_ex(opcode_ex), .funct3_ex(funct3_ex), .funct7_ex(funct7_ex),
        .pc_exe(pc_exe), .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
        .reg_write_ex(reg_write_ex), .valid_ex(valid_ex), .illegal_ex(illegal_ex)
    );

    typedef struct {
        logic        valid, illegal, reg_write, mem_read, mem_write;
        logic [31:0] rs1_data, rs2_data, imm, pc;
        logic [4:0]  rd, rs1, rs2;
        logic [6:0]  opcode, funct7;
        logic [2:0]  funct3;
    } ex_t;

    typedef struct {
        logic [31:0] instr, pc, imm;
        logic [4:0]  rd;
        logic        rw, mr, mw, ill, vld;
    } vec_t;

    logic [31:0] m_regs [32];
    ex_t         exp_q [$];
    ex_t         m_ex;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int fld(input logic [31:0] x, input int hi, input int lo);
        logic [31:0] mask;
        mask = (32'd1 << (hi - lo + 1)) - 32'd1;
        return int'((x >> lo) & mask);
    endfunction

    function automatic int sx(input int v, input int n);
        if (v >= (1 << (n - 1))) return v - (1 << n);
        return v;
    endfunction

    function automatic ex_t bubble_ex();
        ex_t e;
        e = '{default: '0};
        e.pc = RESET_PC;
        return e;
    endfunction

    // Reference decode, reading the model register file as it stands after this cycle's write.
    function automatic ex_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
        ex_t e;
        int  op;
        int  v;
        e = bubble_ex();
        if (ins == 32'd0) return e;
        op = fld(ins, 6, 0);
        v = 0;
        e.valid    = 1'b1;
        e.pc       = pc;
        e.opcode   = 7'(op);
        e.rd       = 5'(fld(ins, 11, 7));
        e.funct3   = 3'(fld(ins, 14, 12));
        e.rs1      = 5'(fld(ins, 19, 15));
        e.rs2      = 5'(fld(ins, 24, 20));
        e.funct7   = 7'(fld(ins, 31, 25));
        e.rs1_data = m_regs[e.rs1];
        e.rs2_data = m_regs[e.rs2];
        case (op)
            3, 19, 103: v = sx(fld(ins, 31, 20), 12);
            35:         v = sx(fld(ins, 31, 25) * 32 + fld(ins, 11, 7), 12);
            99:         v = sx(fld(ins, 31, 31) * 4096 + fld(ins, 7, 7) * 2048 +
                               fld(ins, 30, 25) * 32 + fld(ins, 11, 8) * 2, 13);
            55, 23:     v = fld(ins, 31, 12) * 4096;
            111:        v = sx(fld(ins, 31, 31) * (1 << 20) + fld(ins, 19, 12) * 4096 +
                               fld(ins, 20, 20) * 2048 + fld(ins, 30, 21) * 2, 21);
            default:    v = 0;
        endcase
        e.imm       = 32'(v);
        e.reg_write = (op == 3 || op == 19 || op == 51 || op == 111 || op == 103 ||
                       op == 55 || op == 23) && e.rd != 5'd0;
        e.mem_read  = (op == 3);
        e.mem_write = (op == 35);
        e.illegal   = !(op == 3 || op == 19 || op == 103 || op == 35 || op == 99 ||
                        op == 55 || op == 23 || op == 111 || op == 51);
        return e;
    endfunction

    task automatic compare_ex(input ex_t e);
        check("valid_ex", 32'(valid_ex), 32'(e.valid));
        check("illegal_ex", 32'(illegal_ex), 32'(e.illegal));
        check("reg_write_ex", 32'(reg_write_ex), 32'(e.reg_write));
        check("mem_read_ex", 32'(mem_read_ex), 32'(e.mem_read));
        check("mem_write_ex", 32'(mem_write_ex), 32'(e.mem_write));
        check("rs1_data_ex", rs1_data_ex, e.rs1_data);
        check("rs2_data_ex", rs2_data_ex, e.rs2_data);
        check("imm_ex", imm_ex, e.imm);
        check("pc_exe", pc_exe, e.pc);
        check("rd_ex", 32'(rd_ex), 32'(e.rd));
        check("rs1_ex", 32'(rs1_ex), 32'(e.rs1));
        check("rs2_ex", 32'(rs2_ex), 32'(e.rs2));
        check("opcode_ex", 32'(opcode_ex), 32'(e.opcode));
        check("funct3_ex", 32'(funct3_ex), 32'(e.funct3));
        check("funct7_ex", 32'(funct7_ex), 32'(e.funct7));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          sel;
        int          ops [10];
        ops = '{3, 19, 103, 35, 99, 55, 23, 111, 51, 3};
        sel = $urandom_range(0, 11);
        if (sel == 11) return 32'd0;
        r = $urandom;
        r[6:0]   = (sel == 10) ? 7'($urandom_range(0, 127)) : 7'(ops[sel]);
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    initial begin
        vec_t vecs [11];
        ex_t  nxt;
        logic hazard;
        logic hold;

        vecs[0]  = '{32'hFFF00293, 32'h08, 32'hFFFFFFFF, 5'd5,  1, 0, 0, 0, 1};
        vecs[1]  = '{32'hFE000EE3, 32'h10, 32'hFFFFFFFC, 5'd29, 0, 0, 0, 0, 1};
        vecs[2]  = '{32'h001000EF, 32'h14, 32'h00000800, 5'd1,  1, 0, 0, 0, 1};
        vecs[3]  = '{32'h0000A103, 32'h18, 32'h00000000, 5'd2,  1, 1, 0, 0, 1};
        vecs[4]  = '{32'h12345537, 32'h1C, 32'h12345000, 5'd10, 1, 0, 0, 0, 1};
        vecs[5]  = '{32'hFE512C23, 32'h20, 32'hFFFFFFF8, 5'd24, 0, 0, 1, 0, 1};
        vecs[6]  = '{32'hFFFFF017, 32'h24, 32'hFFFFF000, 5'd0,  0, 0, 0, 0, 1};
        vecs[7]  = '{32'hFFE280E7, 32'h28, 32'hFFFFFFFE, 5'd1,  1, 0, 0, 0, 1};
        vecs[8]  = '{32'h00210233, 32'h2C, 32'h00000000, 5'd4,  1, 0, 0, 0, 1};
        vecs[9]  = '{32'h0000007F, 32'h30, 32'h00000000, 5'd0,  0, 0, 0, 1, 1};
        vecs[10] = '{32'h00000000, 32'h34, 32'h00000000, 5'd0,  0, 0, 0, 0, 0};

        // Reset values, observed while rst_n is still low.
        #3;
        compare_ex(bubble_ex());
        check("reset stall_fe", 32'(stall_fe), 32'd0);
        #9 rst_n = 1'b1;

        foreach (vecs[i]) begin
            instruction_dec = vecs[i].instr;
            pc_dec          = vecs[i].pc;
            step();
            check($sformatf("vec%0d imm", i), imm_ex, vecs[i].imm);
            check($sformatf("vec%0d rd", i), 32'(rd_ex), 32'(vecs[i].rd));
            check($sformatf("vec%0d reg_write", i), 32'(reg_write_ex), 32'(vecs[i].rw));
            check($sformatf("vec%0d mem_read", i), 32'(mem_read_ex), 32'(vecs[i].mr));
            check($sformatf("vec%0d mem_write", i), 32'(mem_write_ex), 32'(vecs[i].mw));
            check($sformatf("vec%0d illegal", i), 32'(illegal_ex), 32'(vecs[i].ill));
            check($sformatf("vec%0d valid", i), 32'(valid_ex), 32'(vecs[i].vld));
            check($sformatf("vec%0d pc", i), pc_exe, vecs[i].vld ? vecs[i].pc : RESET_PC);
            check($sformatf("vec%0d stall", i), 32'(stall_fe), 32'd0);
        end

        // Writeback bypass, stored value, and x0 immunity.
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        instruction_dec = 32'h000180B3; pc_dec = 32'h40;
        step();
        check("bypass rs1_data", rs1_data_ex, 32'hDEADBEEF);
        check("bypass rs2_data", rs2_data_ex, 32'd0);
        wb_en = 1'b0;
        step();
        check("stored x3", rs1_data_ex, 32'hDEADBEEF);
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678;
        instruction_dec = 32'h000000B3;
        step();
        check("x0 bypass", rs1_data_ex, 32'd0);
        wb_en = 1'b0;
        step();
        check("x0 stored", rs1_data_ex, 32'd0);

        // Load-use: exactly one stall cycle and one bubble, then the consumer issues.
        instruction_dec = 32'h0000A103; pc_dec = 32'h50;
        step();
        check("lw mem_read", 32'(mem_read_ex), 32'd1);
        instruction_dec = 32'h00210233; pc_dec = 32'h54;
        #1;
        check("load-use stall", 32'(stall_fe), 32'd1);
        step();
        check("load-use bubble valid", 32'(valid_ex), 32'd0);
        check("load-use bubble pc", pc_exe, RESET_PC);
        check("stall released", 32'(stall_fe), 32'd0);
        step();
        check("consumer valid", 32'(valid_ex), 32'd1);
        check("consumer rs1", 32'(rs1_ex), 32'd2);
        check("consumer rs2", 32'(rs2_ex), 32'd2);
        check("consumer pc", pc_exe, 32'h54);

        // Flush in the hazard cycle: no stall, bubble, and the ADD is not repeated.
        instruction_dec = 32'h0000A103; pc_dec = 32'h60;
        step();
        instruction_dec = 32'h00210233; pc_dec = 32'h64; branch = 1'b1;
        #1;
        check("flush stall", 32'(stall_fe), 32'd0);
        step();
        check("flush bubble", 32'(valid_ex), 32'd0);
        branch = 1'b0;
        instruction_dec = 32'hFFF00293; pc_dec = 32'h80;
        step();
        check("after flush opcode", 32'(opcode_ex), 32'h13);
        check("after flush pc", pc_exe, 32'h80);

        // Asynchronous reset in the middle of a stall.
        instruction_dec = 32'h0000A103; pc_dec = 32'h90;
        step();
        instruction_dec = 32'h00210233; pc_dec = 32'h94;
        #1;
        check("pre-reset stall", 32'(stall_fe), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("reset drops stall", 32'(stall_fe), 32'd0);
        compare_ex(bubble_ex());
        rst_n = 1'b1;
        instruction_dec = 32'h000180B3; pc_dec = 32'hA0;
        step();
        check("regs cleared by reset", rs1_data_ex, 32'd0);
        check("post-reset valid", 32'(valid_ex), 32'd1);

        // Random traffic against the reference model; fetch holds whenever a stall is expected.
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_ex = bubble_ex();
        hold = 1'b0;
        pc_dec = 32'h1000;
        step();
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                instruction_dec = rand_instr();
                pc_dec = pc_dec + 32'd4;
            end
            branch  = ($urandom_range(0, 9) == 0);
            wb_en   = 1'($urandom_range(0, 1));
            wb_rd   = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            hazard = m_ex.valid && m_ex.mem_read && m_ex.rd != 5'd0 &&
                     (m_ex.rd == instruction_dec[19:15] || m_ex.rd == instruction_dec[24:20]);
            #1;
            check("rand stall_fe", 32'(stall_fe), 32'(hazard && !branch));
            hold = hazard && !branch;
            if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
            nxt = (branch || hazard) ? bubble_ex() : model_decode(instruction_dec, pc_dec);
            exp_q.push_back(nxt);
            step();
            m_ex = exp_q.pop_front();
            compare_ex(m_ex);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
